div_clk_monitor: RTL and testbench
==================================

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the high/low phase counters.
REQ-002 SHALL have parameter LOCK_N, default 4, number of consecutive equal periods required for lock.
REQ-003 SHALL have port clk_in  input  1  monitor clock; the same clock that drives the divider under observation.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port div_clk  input  1  divided clock under observation, treated as asynchronous data.
REQ-006 SHALL have port high_cnt  output  CNT_W  last completed high-phase length, in clk_in cycles.
REQ-007 SHALL have port low_cnt  output  CNT_W  last completed low-phase length, in clk_in cycles.
REQ-008 SHALL have port period  output  CNT_W+1  high_cnt+low_cnt of the last completed period.
REQ-009 SHALL have port meas_valid  output  1  one-cycle pulse when high_cnt/low_cnt/period update.
REQ-010 SHALL have port duty_ok  output  1  high_cnt and low_cnt differ by at most 1.
REQ-011 SHALL have port locked  output  1  LOCK_N consecutive equal periods measured.
REQ-012 SHALL have port ovf  output  1  sticky: a phase counter saturated (stuck div_clk).

Function
REQ-013 SHALL synchronise div_clk through 2 flops on posedge clk_in, plus one delay flop for edge detection; rise = sync & ~dly, fall = ~sync & dly.
REQ-014 SHALL implement FSM states INIT, HIGH, LOW, STUCK.
REQ-015 INIT: counters idle; on rise -> HIGH with phase counter = 1; falls are ignored.
REQ-016 HIGH: counter increments each cycle; on fall, latch counter into the high register, reload counter to 1, and go to LOW.
REQ-017 LOW: counter increments each cycle; on rise, latch counter into low_cnt, copy the high register to high_cnt, compute period, pulse meas_valid next cycle, reload counter to 1, and go to HIGH.
REQ-018 First meas_valid SHALL occur only after one full high+low period following INIT; a partial first phase is never reported.
REQ-019 Phase counter SHALL saturate at 2^CNT_W-1; on reaching saturation in HIGH or LOW: set ovf, clear locked, and go to STUCK.
REQ-020 STUCK: wait for any edge (rise or fall), then go to INIT; ovf stays set until reset.
REQ-021 Period arithmetic SHALL be unsigned CNT_W+1 bits, with no truncation.
REQ-022 duty_ok SHALL be combinational from the registered high_cnt/low_cnt; it is 0 while no measurement has been made.
REQ-023 Lock counter SHALL increment when a new period equals the previous period (saturating at LOCK_N) and reload to 1 on mismatch; locked = (lock counter == LOCK_N).
REQ-024 The first measured period SHALL set lock counter to 1.
REQ-025 Outputs other than meas_valid SHALL hold their values between measurements.

Reset
REQ-026 When rst is low, all flops SHALL clear asynchronously: state=INIT, synchroniser=0, counters=0, high_cnt=low_cnt=period=0, meas_valid=0, locked=0, ovf=0.
REQ-027 Reset asserted mid-measurement SHALL discard the partial phase; after release, the block behaves as from power-up.

Structure
REQ-028 FSM state encoding and LOCK_N default SHALL live in shared package div_mon_pkg.
REQ-029 The synchroniser plus edge detector SHALL be sub-module sync_edge_det (ports clk_in, rst, d, rise, fall).

Verification
REQ-030 Drive div_clk from a divide-by-7 50% divider on the same clk_in -> period=7, {high_cnt,low_cnt} in {3,4}/{4,3}, duty_ok=1, locked=1 by the 5th meas_valid.
REQ-031 Even divide-by-8 -> high_cnt=4, low_cnt=4, period=8, duty_ok=1, locked=1.
REQ-032 div_clk high 2, low 6 -> period=8, duty_ok=0, locked still asserts.
REQ-033 Hold div_clk low for 300 cycles after lock (CNT_W=8) -> ovf=1 and locked=0 at count 255; after the next rise, re-measurement occurs and ovf stays 1.
REQ-034 Change divide 7->9 while locked -> locked drops on the first period=9 meas_valid, then reasserts after 4 equal periods.
REQ-035 Assert rst during a HIGH phase -> all outputs 0 within the reset; no meas_valid until one full period after release.

Source files
------------

// File: rtl/div_mon_pkg.sv
// rtl/div_mon_pkg.sv - shared FSM encoding and lock default for div_clk_monitor
package div_mon_pkg;

  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_INIT  = 2'd0;
  localparam mon_state_t ST_HIGH  = 2'd1;
  localparam mon_state_t ST_LOW   = 2'd2;
  localparam mon_state_t ST_STUCK = 2'd3;

  localparam int unsigned LOCK_N_DEF = 4;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchroniser with rise/fall edge detection
module sync_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Bring d into the clk_in domain, then keep one extra sample to find edges
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures high/low phase, period, duty and lock of a divided clock
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LOCK_N = LOCK_N_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             duty_ok,
  output logic             locked,
  output logic             ovf
);

  localparam int unsigned      LW        = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [LW-1:0]    LOCK_FULL = LW'(LOCK_N);
  localparam logic [LW-1:0]    LOCK_ONE  = LW'(1);

  logic rise;
  logic fall;

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             meas_q, meas_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       settle_q, settle_d;

  logic             settle_done;
  logic             sat_next;
  logic [CNT_W:0]   new_period;
  logic [CNT_W-1:0] diff;

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (div_clk),
    .rise   (rise),
    .fall   (fall)
  );

  // The synchroniser leaves reset at 0, so an input already high looks like a
  // rise; edges are trusted only once the pipeline has refilled after reset.
  assign settle_done = (settle_q == 2'd3);
  assign sat_next    = (cnt_q == CNT_MAX - CNT_ONE);
  assign new_period  = {1'b0, hi_q} + {1'b0, cnt_q};

  // Phase-tracking FSM, measurement capture and lock bookkeeping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    period_d   = period_q;
    meas_d     = 1'b0;
    lock_d     = lock_q;
    ovf_d      = ovf_q;
    settle_d   = settle_done ? settle_q : settle_q + 2'd1;
    case (state_q)
      ST_INIT: begin
        if (rise && settle_done) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          hi_d    = cnt_q;
          cnt_d   = CNT_ONE;
          state_d = ST_LOW;
        end else if (sat_next) begin
          cnt_d   = CNT_MAX;
          ovf_d   = 1'b1;
          lock_d  = '0;
          state_d = ST_STUCK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOW: begin
        if (rise) begin
          low_cnt_d  = cnt_q;
          high_cnt_d = hi_q;
          period_d   = new_period;
          meas_d     = 1'b1;
          cnt_d      = CNT_ONE;
          state_d    = ST_HIGH;
          if (new_period != period_q) begin
            lock_d = LOCK_ONE;
          end else if (lock_q != LOCK_FULL) begin
            lock_d = lock_q + LOCK_ONE;
          end
        end else if (sat_next) begin
          cnt_d   = CNT_MAX;
          ovf_d   = 1'b1;
          lock_d  = '0;
          state_d = ST_STUCK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STUCK: begin
        if (rise || fall) begin
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      hi_q       <= '0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      period_q   <= '0;
      meas_q     <= 1'b0;
      lock_q     <= '0;
      ovf_q      <= 1'b0;
      settle_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      period_q   <= period_d;
      meas_q     <= meas_d;
      lock_q     <= lock_d;
      ovf_q      <= ovf_d;
      settle_q   <= settle_d;
    end
  end

  assign diff = (high_cnt_q >= low_cnt_q) ? (high_cnt_q - low_cnt_q)
                                          : (low_cnt_q - high_cnt_q);

  // A zero period means nothing has been measured yet
  assign duty_ok    = (period_q != '0) && (diff <= CNT_ONE);
  assign high_cnt   = high_cnt_q;
  assign low_cnt    = low_cnt_q;
  assign period     = period_q;
  assign meas_valid = meas_q;
  assign locked     = (lock_q == LOCK_FULL);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - self-checking bench for div_clk_monitor
module tb_div_clk_monitor;

  localparam int CNT_W  = 8;
  localparam int LOCK_N = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             div_clk;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic             duty_ok;
  logic             locked;
  logic             ovf;

  div_clk_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .div_clk    (div_clk),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period     (period),
    .meas_valid (meas_valid),
    .duty_ok    (duty_ok),
    .locked     (locked),
    .ovf        (ovf)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] l;
    logic [CNT_W:0]   p;
    logic             dk;
    logic             lk;
    logic             ov;
  } meas_t;

  int    tests_run    = 0;
  int    tests_failed = 0;
  meas_t exp_q[$];
  int    hist[$];
  int    m_mode;
  int    m_prev;
  int    m_run;
  int    m_hlen;
  bit    m_ovf;
  bit    model_on;
  int    meas_seen;
  bit    last_meas;
  int    pat_h;
  int    pat_l;
  int    pat_pos;

  function automatic void push_meas(int h, int l);
    meas_t e;
    int    n;
    int    last;
    hist.push_back(h + l);
    last = hist[hist.size() - 1];
    n = 0;
    for (int i = hist.size() - 1; i >= 0 && n < LOCK_N; i--) begin
      if (hist[i] != last) break;
      n++;
    end
    e.h  = CNT_W'(h);
    e.l  = CNT_W'(l);
    e.p  = (CNT_W + 1)'(h + l);
    e.dk = (((h > l) ? h - l : l - h) <= 1);
    e.lk = (n == LOCK_N);
    e.ov = m_ovf;
    exp_q.push_back(e);
  endfunction

  // Run-length view of the waveform: mode 0 waits for a rise, 1 tracks phases, 2 is stuck
  function automatic void model_sample(int x);
    if (x != m_prev) begin
      if (m_mode == 0) begin
        if (x == 1) begin
          m_mode = 1;
          m_run  = 1;
        end
      end else if (m_mode == 1) begin
        if (x == 0) begin
          m_hlen = m_run;
        end else begin
          push_meas(m_hlen, m_run);
        end
        m_run = 1;
      end else begin
        m_mode = 0;
      end
    end else if (m_mode == 1) begin
      m_run++;
      if (m_run >= SAT) begin
        m_ovf  = 1'b1;
        m_mode = 2;
        hist.delete();
      end
    end
    m_prev = x;
  endfunction

  function automatic void model_reset(int lvl);
    exp_q.delete();
    hist.delete();
    m_mode   = 0;
    m_prev   = lvl;
    m_run    = 0;
    m_hlen   = 0;
    m_ovf    = 1'b0;
    model_on = 1'b1;
  endfunction

  task automatic step(input logic x);
    meas_t e;
    @(posedge clk_in);
    #1;
    last_meas = 1'b0;
    if (meas_valid === 1'b1) begin
      last_meas = 1'b1;
      meas_seen++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL meas_unexpected: meas_valid=1 period=%0d, expected no measurement", period);
      end else begin
        e = exp_q.pop_front();
        if (high_cnt !== e.h || low_cnt !== e.l || period !== e.p ||
            duty_ok !== e.dk || locked !== e.lk || ovf !== e.ov) begin
          tests_failed++;
          $display("FAIL meas_check: got h=%0d l=%0d p=%0d duty=%0b lock=%0b ovf=%0b, expected h=%0d l=%0d p=%0d duty=%0b lock=%0b ovf=%0b",
                   high_cnt, low_cnt, period, duty_ok, locked, ovf, e.h, e.l, e.p, e.dk, e.lk, e.ov);
        end
      end
    end
    div_clk = x;
    if (model_on) model_sample(int'(x));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(pat_pos < pat_h);
      pat_pos = (pat_pos + 1) % (pat_h + pat_l);
    end
  endtask

  task automatic set_pattern(input int h, input int l);
    pat_h   = h;
    pat_l   = l;
    pat_pos = 0;
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    div_clk  = 1'b0;
    model_on = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    tests_run++;
    if (high_cnt !== '0 || low_cnt !== '0 || period !== '0) begin
      tests_failed++;
      $display("FAIL reset_counts: got h=%0d l=%0d p=%0d, expected 0 0 0", high_cnt, low_cnt, period);
    end
    tests_run++;
    if (meas_valid !== 1'b0 || duty_ok !== 1'b0 || locked !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got mv=%0b duty=%0b lock=%0b ovf=%0b, expected all 0", meas_valid, duty_ok, locked, ovf);
    end
    rst = 1'b1;
    model_reset(0);
    set_pattern(0, 1);
    run_cycles(6);
  endtask

  task automatic test_div7;
    int start;
    start = meas_seen;
    set_pattern(4, 3);
    for (int i = 0; i < 200 && (meas_seen - start) < 5; i++) run_cycles(1);
    tests_run++;
    if (meas_seen - start != 5) begin
      tests_failed++;
      $display("FAIL div7_meas_count: got %0d measurements, expected 5", meas_seen - start);
    end
    tests_run++;
    if (locked !== 1'b1 || period !== 9'd7 || duty_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL div7_lock: got lock=%0b p=%0d duty=%0b, expected 1 7 1", locked, period, duty_ok);
    end
    tests_run++;
    if (!((high_cnt === 8'd4 && low_cnt === 8'd3) || (high_cnt === 8'd3 && low_cnt === 8'd4))) begin
      tests_failed++;
      $display("FAIL div7_phases: got h=%0d l=%0d, expected 4/3 or 3/4", high_cnt, low_cnt);
    end
  endtask

  task automatic test_div8;
    set_pattern(4, 4);
    run_cycles(64);
    tests_run++;
    if (high_cnt !== 8'd4 || low_cnt !== 8'd4 || period !== 9'd8 || duty_ok !== 1'b1 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL div8: got h=%0d l=%0d p=%0d duty=%0b lock=%0b, expected 4 4 8 1 1",
               high_cnt, low_cnt, period, duty_ok, locked);
    end
  endtask

  task automatic test_asym;
    set_pattern(2, 6);
    run_cycles(64);
    tests_run++;
    if (high_cnt !== 8'd2 || low_cnt !== 8'd6 || period !== 9'd8 || duty_ok !== 1'b0 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL asym: got h=%0d l=%0d p=%0d duty=%0b lock=%0b, expected 2 6 8 0 1",
               high_cnt, low_cnt, period, duty_ok, locked);
    end
  endtask

  task automatic test_stuck;
    int start;
    for (int i = 0; i < 8 && pat_pos != 0; i++) run_cycles(1);
    run_cycles(2);
    for (int i = 0; i < 257; i++) step(1'b0);
    tests_run++;
    if (ovf !== 1'b0 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL stuck_before_sat: got ovf=%0b lock=%0b, expected 0 1", ovf, locked);
    end
    step(1'b0);
    tests_run++;
    if (ovf !== 1'b1 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL stuck_at_sat: got ovf=%0b lock=%0b, expected 1 0", ovf, locked);
    end
    for (int i = 0; i < 42; i++) step(1'b0);
    start = meas_seen;
    set_pattern(4, 4);
    run_cycles(100);
    tests_run++;
    if (meas_seen == start || ovf !== 1'b1 || high_cnt !== 8'd4 || low_cnt !== 8'd4 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL stuck_recover: got meas=%0d ovf=%0b h=%0d l=%0d lock=%0b, expected >0 1 4 4 1",
               meas_seen - start, ovf, high_cnt, low_cnt, locked);
    end
  endtask

  task automatic test_change_div;
    int n9;
    bit first_ok;
    set_pattern(4, 3);
    run_cycles(70);
    tests_run++;
    if (locked !== 1'b1 || period !== 9'd7) begin
      tests_failed++;
      $display("FAIL chg_pre_lock: got lock=%0b p=%0d, expected 1 7", locked, period);
    end
    set_pattern(5, 4);
    n9 = 0;
    first_ok = 1'b0;
    for (int i = 0; i < 200 && n9 < 4; i++) begin
      run_cycles(1);
      if (last_meas && period !== 9'd7) begin
        n9++;
        tests_run++;
        if (period !== 9'd9 || locked !== (n9 == 4)) begin
          tests_failed++;
          $display("FAIL chg_meas%0d: got p=%0d lock=%0b, expected 9 %0b", n9, period, locked, n9 == 4);
        end
      end
    end
    tests_run++;
    if (n9 != 4) begin
      tests_failed++;
      $display("FAIL chg_count: got %0d period-9 measurements, expected 4", n9);
    end
  endtask

  task automatic test_reset_mid;
    int start;
    set_pattern(10, 10);
    run_cycles(100);
    run_cycles(2);
    rst      = 1'b0;
    model_on = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if (high_cnt !== '0 || low_cnt !== '0 || period !== '0 || meas_valid !== 1'b0 ||
        duty_ok !== 1'b0 || locked !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got h=%0d l=%0d p=%0d mv=%0b duty=%0b lock=%0b ovf=%0b, expected all 0",
               high_cnt, low_cnt, period, meas_valid, duty_ok, locked, ovf);
    end
    run_cycles(3);
    rst = 1'b1;
    model_reset(int'(div_clk));
    start = meas_seen;
    run_cycles(30);
    tests_run++;
    if (meas_seen != start) begin
      tests_failed++;
      $display("FAIL mid_early_meas: got %0d measurements, expected 0", meas_seen - start);
    end
    run_cycles(40);
    tests_run++;
    if (meas_seen == start || high_cnt !== 8'd10 || low_cnt !== 8'd10 || ovf !== 1'b0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_after: got meas=%0d h=%0d l=%0d ovf=%0b lock=%0b, expected >0 10 10 0 0",
               meas_seen - start, high_cnt, low_cnt, ovf, locked);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      set_pattern(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
      run_cycles(int'($urandom_range(40, 120)));
    end
    for (int i = 0; i < 8; i++) step(div_clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d outstanding measurements, expected 0", exp_q.size());
    end
  endtask

  initial begin
    meas_seen = 0;
    last_meas = 1'b0;
    test_reset();
    test_div7();
    test_div8();
    test_asym();
    test_stuck();
    test_change_div();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
